// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcodes, widths and the hard-wired zero register.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/wb_dest_decode.sv
// Destination register decode from an instruction word.
//   ir   : instruction word
//   dest : R-type -> rd, jal -> r31, everything else -> rt
module wb_dest_decode
  import mips_pkg::*;
(
  input  logic [31:0]           ir,
  output logic [REG_ADDR_W-1:0] dest
);

  logic [5:0] opcode;

  // Fields not involved in the destination choice.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[25:21], ir[10:0]};

  assign opcode = ir[31:26];

  always_comb begin
    dest = ir[20:16];
    unique case (opcode)
      OP_RTYPE: dest = ir[15:11];
      OP_JAL:   dest = 5'd31;
      default:  dest = ir[20:16];
    endcase
  end

endmodule : wb_dest_decode

// File: rtl/wb_regfile.sv
// Write-back stage plus 32-entry architectural register file.
//   clk, rst_n        : clock, synchronous active-low reset
//   ir, aluout,
//   readdata,
//   RegWrite, MemtoReg: MEM/WB pipeline outputs
//   rs_addr, rt_addr  : ID read addresses
//   rs_data, rt_data  : combinational read data with write-through bypass
//   wb_en/dest/data   : write-back bus (combinational) for forwarding
//   wb_count          : registered count of committed writes
module wb_regfile
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           ir,
  input  logic [DATA_W-1:0]     aluout,
  input  logic [DATA_W-1:0]     readdata,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0]     wb_data,
  output logic [31:0]           wb_count
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [31:0]       wb_count_q;
  logic [31:0]       wb_count_d;

  wb_dest_decode u_dest_decode (
    .ir   (ir),
    .dest (wb_dest)
  );

  // Write-back value select and commit qualifier; r0 is never a real target.
  assign wb_data = MemtoReg ? readdata : aluout;
  assign wb_en   = RegWrite && (wb_dest != REG_ZERO);

  // Next state of the array and commit counter.
  always_comb begin
    regs_d     = regs_q;
    wb_count_d = wb_count_q;
    if (wb_en) begin
      regs_d[wb_dest] = wb_data;
      wb_count_d      = wb_count_q + 32'd1;
    end
  end

  // Single-edge synchronous clear; a write in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

  // Read port A: zero register, then same-cycle bypass, then array.
  always_comb begin
    rs_data = regs_q[rs_addr];
    if (rs_addr == REG_ZERO) begin
      rs_data = '0;
    end else if (wb_en && (rs_addr == wb_dest)) begin
      rs_data = wb_data;
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rt_data = regs_q[rt_addr];
    if (rt_addr == REG_ZERO) begin
      rt_data = '0;
    end else if (wb_en && (rt_addr == wb_dest)) begin
      rt_data = wb_data;
    end
  end

  assign wb_count = wb_count_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_wb_regfile;

  localparam int SEL_RS    = 0;
  localparam int SEL_RT    = 1;
  localparam int SEL_EN    = 2;
  localparam int SEL_DEST  = 3;
  localparam int SEL_DATA  = 4;
  localparam int SEL_COUNT = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] ir;
  logic [31:0] aluout;
  logic [31:0] readdata;
  logic        RegWrite;
  logic        MemtoReg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [31:0] wb_count;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  wb_regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir       (ir),
    .aluout   (aluout),
    .readdata (readdata),
    .RegWrite (RegWrite),
    .MemtoReg (MemtoReg),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .wb_en    (wb_en),
    .wb_dest  (wb_dest),
    .wb_data  (wb_data),
    .wb_count (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are settled at the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.sel)
        SEL_RS:    act = rs_data;
        SEL_RT:    act = rt_data;
        SEL_EN:    act = {31'd0, wb_en};
        SEL_DEST:  act = {27'd0, wb_dest};
        SEL_DATA:  act = wb_data;
        default:   act = wb_count;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i_ir, input logic [31:0] i_alu,
                       input logic [31:0] i_rd, input logic i_rw, input logic i_m2r,
                       input logic [4:0] i_rs, input logic [4:0] i_rt);
    ir       = i_ir;
    aluout   = i_alu;
    readdata = i_rd;
    RegWrite = i_rw;
    MemtoReg = i_m2r;
    rs_addr  = i_rs;
    rt_addr  = i_rt;
  endtask

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    step();
    step();
    rst_n = 1'b1;

    // Post-reset: every register reads zero on both ports.
    expect_val("reset_count", SEL_COUNT, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      expect_val("reset_rs", SEL_RS, 32'h0);
      expect_val("reset_rt", SEL_RT, 32'h0);
      step();
    end

    // add $8,$9,$10 -> r8 = 0x1234
    drive(32'h012A4020, 32'h0000_1234, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
    expect_val("rtype_en", SEL_EN, 32'h1);
    expect_val("rtype_dest", SEL_DEST, 32'd8);
    expect_val("rtype_data", SEL_DATA, 32'h1234);
    step();
    // No bypass when RegWrite is low, even if dest matches.
    drive(32'h012A4020, 32'h0000_0BAD, 32'h0, 1'b0, 1'b0, 5'd8, 5'd8);
    expect_val("rtype_read", SEL_RS, 32'h1234);
    expect_val("rtype_nobyp", SEL_RT, 32'h1234);
    expect_val("rtype_en_off", SEL_EN, 32'h0);
    expect_val("rtype_count", SEL_COUNT, 32'd1);
    step();

    // lw $5 -> readdata selected, both ports bypass in the same cycle
    drive(32'h8C450004, 32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd5, 5'd5);
    expect_val("lw_dest", SEL_DEST, 32'd5);
    expect_val("lw_data", SEL_DATA, 32'hDEAD_BEEF);
    expect_val("lw_byp_rs", SEL_RS, 32'hDEAD_BEEF);
    expect_val("lw_byp_rt", SEL_RT, 32'hDEAD_BEEF);
    step();
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd5, 5'd8);
    expect_val("lw_read", SEL_RS, 32'hDEAD_BEEF);
    expect_val("lw_r8_kept", SEL_RT, 32'h1234);
    expect_val("lw_count", SEL_COUNT, 32'd2);
    step();

    // jal -> r31 = link address
    drive(32'h0C000010, 32'h0000_0048, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
    expect_val("jal_dest", SEL_DEST, 32'd31);
    expect_val("jal_en", SEL_EN, 32'h1);
    step();
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd31, 5'd5);
    expect_val("jal_read", SEL_RS, 32'h48);
    expect_val("jal_r5_kept", SEL_RT, 32'hDEAD_BEEF);
    expect_val("jal_count", SEL_COUNT, 32'd3);
    step();

    // add $0,$9,$9 -> suppressed, r0 reads 0 even with a pending "bypass"
    drive(32'h01290020, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
    expect_val("r0_en", SEL_EN, 32'h0);
    expect_val("r0_dest", SEL_DEST, 32'd0);
    expect_val("r0_rs", SEL_RS, 32'h0);
    expect_val("r0_rt", SEL_RT, 32'h0);
    step();
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    expect_val("r0_read", SEL_RS, 32'h0);
    expect_val("r0_count", SEL_COUNT, 32'd3);
    step();

    // Back-to-back addi writes to r8: last wins, bypass beats the stale value
    drive(32'h20080000, 32'h0000_0011, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
    expect_val("b2b_dest", SEL_DEST, 32'd8);
    step();
    drive(32'h20080000, 32'h0000_0022, 32'h0, 1'b1, 1'b0, 5'd8, 5'd0);
    expect_val("b2b_byp", SEL_RS, 32'h22);
    step();
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd8, 5'd0);
    expect_val("b2b_read", SEL_RS, 32'h22);
    expect_val("b2b_count", SEL_COUNT, 32'd5);
    step();

    // Counter wrap: preload all-ones, then commit one write
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    expect_val("wrap_preload", SEL_COUNT, 32'hFFFF_FFFF);
    step();
    drive(32'h20090000, 32'h0000_0005, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
    expect_val("wrap_pre", SEL_COUNT, 32'hFFFF_FFFF);
    step();
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd9, 5'd0);
    expect_val("wrap_count", SEL_COUNT, 32'h0);
    expect_val("wrap_r9", SEL_RS, 32'h5);
    step();

    // Reset vs. write to r3 in the same cycle: reset wins
    drive(32'h20030000, 32'h0000_0077, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
    step();
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd3, 5'd0);
    expect_val("r3_pre", SEL_RS, 32'h77);
    expect_val("r3_pre_count", SEL_COUNT, 32'd1);
    step();
    drive(32'h20030000, 32'h0000_0099, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd3, 5'd8);
    expect_val("rst_r3", SEL_RS, 32'h0);
    expect_val("rst_r8", SEL_RT, 32'h0);
    expect_val("rst_count", SEL_COUNT, 32'h0);
    step();

    // Drain anything the monitor has not yet consumed.
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb_regfile

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 5-stage MIPS pipeline. It consumes the MEM/WB pipeline outputs (instruction, ALU result, load data, RegWrite, MemtoReg), selects the write-back value, and decodes the destination register from the instruction word. It commits the write to a 32×32 register file on the clock edge. It also serves the ID stage's two read ports with same-cycle write-through bypass, and exports the write-back bus to the forwarding unit.

## Interface
Parameters:
- DATA_W, 32, register and data width
- NREGS, 32, number of architectural registers (address width = 5)

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- ir  in  32  instruction in write-back, from MEM/WB ir_out
- aluout  in  32  ALU result, or link address for jal, from MEM/WB aluout_out
- readdata  in  32  load data, from MEM/WB readdata_out
- RegWrite  in  1  write enable, from MEM/WB RegWrite_out
- MemtoReg  in  1  1 = write readdata, 0 = write aluout
- rs_addr  in  5  ID read port A address
- rt_addr  in  5  ID read port B address
- rs_data  out  32  read port A data
- rt_data  out  32  read port B data
- wb_en  out  1  write actually committing this cycle
- wb_dest  out  5  decoded destination register
- wb_data  out  32  selected write-back value
- wb_count  out  32  count of committed register writes

## Operation
Destination decode uses opcode = ir[31:26]:
- opcode 6'h00 (R-type): dest = ir[15:11]
- opcode 6'h03 (jal): dest = 5'd31
- all other opcodes: dest = ir[20:16]

Write-back:
- wb_data = MemtoReg ? readdata : aluout
- wb_en = RegWrite && (wb_dest != 0)
- On the rising edge with rst_n = 1 and wb_en = 1: regs[wb_dest] ← wb_data, and wb_count ← wb_count + 1, wrapping modulo 2^32.

Register 0:
- r0 is never written.
- Reads of address 0 always return 0, including during a bypass.

Read ports (combinational):
- rs_data = 0 if rs_addr == 0.
- Otherwise rs_data = wb_data if wb_en and rs_addr == wb_dest.
- Otherwise rs_data = regs[rs_addr].
- rt_data follows the same rule with rt_addr.
- The bypass resolves the same-cycle WB→ID hazard, so the ID stage needs no extra stall for it.

Reset:
- With rst_n = 0 at an edge, all 32 registers and wb_count clear to 0 in that single edge.
- A write presented in the same cycle is dropped; reset wins.

## Timing
- Write latency: data presented in cycle N is visible in regs from cycle N+1. It is visible on rs_data/rt_data in cycle N through the bypass.
- Read latency: 0 cycles (combinational from address and write-back inputs).
- Reset values: all registers 0 and wb_count 0 after the first rst_n = 0 edge. Read outputs and wb_* are combinational, so after reset reads return 0.
- wb_en, wb_dest and wb_data are pure functions of the current inputs, with no added delay.
- Simultaneous events:
  - Both read ports may hit the same address, and may both bypass.
  - Back-to-back writes to the same register: the last write wins.
- A mid-operation reset discards any pending write in that cycle. The pipeline is expected to flush alongside.
- wb_count wraps from 0xFFFFFFFF to 0x00000000 on the next committed write.

## Structure
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE = 6'h00 and OP_JAL = 6'h03
  - REG_ADDR_W = 5 and DATA_W = 32
  - the register-0 index constant
- One natural sub-module: wb_dest_decode, a combinational map from ir to dest, reused by the hazard unit.
- The register array is a flop array reset synchronously. No vendor RAM is used, because of the single-edge clear.

## Test plan
- Reset, then read all 32 addresses on both ports → every read returns 0x00000000; wb_count = 0.
- R-type ir = 0x012A4020 (add $8,$9,$10), aluout = 0x0000_1234, MemtoReg = 0, RegWrite = 1 → wb_dest = 8, wb_en = 1. Next cycle rs_addr = 8 reads 0x1234, and wb_count = 1.
- lw ir = 0x8C450004 (rt = 5), readdata = 0xDEAD_BEEF, aluout = 0x40, MemtoReg = 1 → r5 = 0xDEADBEEF. In the same cycle, rs_addr = rt_addr = 5 both return 0xDEADBEEF via the bypass.
- jal ir = 0x0C000010, aluout = 0x0000_0048 → r31 = 0x48.
- Write to r0 (R-type with rd = 0, aluout = 0xFFFF_FFFF) → wb_en = 0, reads of r0 return 0, and wb_count is unchanged.
- Two further cases:
  - Preload wb_count to 0xFFFFFFFF via 2^32−1 writes, or with a bench force, then commit one write → wb_count = 0.
  - Assert rst_n = 0 together with RegWrite = 1 to r3 → r3 stays 0.
